// File: rtl/core2axi4l_pipe.sv
// rtl/core2axi4l_pipe.sv - pipelined core request/response bus to AXI4-Lite master bridge
//
// Purpose: turns a simple req/gnt/rvalid core bus into AXI4-Lite transactions,
// keeping up to MAX_OUT transfers in flight in a single direction at a time.
// Address, write data and strobes are passed straight through; the core holds
// its request stable until granted.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   core_req_i .. core_wdata_i   core request: req, write-enable, byte enables, address, data
//   core_gnt_o              request accepted (AR handshake, or last of AW/W handshakes)
//   core_rvalid_o           response strobe, same cycle as the R or B handshake
//   core_rdata_o            read data on read responses, zero otherwise
//   core_err_o              response was SLVERR/DECERR
//   axi_aw*/axi_w*/axi_b*/axi_ar*/axi_r*   AXI4-Lite master port
module core2axi4l_pipe #(
  parameter int         AW      = 32,
  parameter int         DW      = 32,
  parameter int         MAX_OUT = 4,
  parameter logic [2:0] PROT    = 3'b000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            core_req_i,
  input  logic            core_we_i,
  input  logic [DW/8-1:0] core_be_i,
  input  logic [AW-1:0]   core_addr_i,
  input  logic [DW-1:0]   core_wdata_i,
  output logic            core_gnt_o,
  output logic            core_rvalid_o,
  output logic            core_err_o,
  output logic [DW-1:0]   core_rdata_o,
  output logic            axi_awvalid_o,
  input  logic            axi_awready_i,
  output logic [AW-1:0]   axi_awaddr_o,
  output logic [2:0]      axi_awprot_o,
  output logic            axi_wvalid_o,
  input  logic            axi_wready_i,
  output logic [DW-1:0]   axi_wdata_o,
  output logic [DW/8-1:0] axi_wstrb_o,
  input  logic            axi_bvalid_i,
  output logic            axi_bready_o,
  input  logic [1:0]      axi_bresp_i,
  output logic            axi_arvalid_o,
  input  logic            axi_arready_i,
  output logic [AW-1:0]   axi_araddr_o,
  output logic [2:0]      axi_arprot_o,
  input  logic            axi_rvalid_i,
  output logic            axi_rready_o,
  input  logic [DW-1:0]   axi_rdata_i,
  input  logic [1:0]      axi_rresp_i
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;

  logic dir_ok, issuable;
  logic aw_hs, w_hs, ar_hs, r_hs, b_hs;
  logic gnt, rsp;
  logic unused_resp_bits;

  // Only the error bit of each response code matters to the core.
  assign unused_resp_bits = ^{axi_rresp_i[0], axi_bresp_i[0]};

  // Same-direction requests may pipeline; the opposite direction waits for
  // the state to fall back to IDLE, which only happens once cnt_q is zero.
  assign dir_ok = (state_q == ST_IDLE) ||
                  ((state_q == ST_RD) && !core_we_i) ||
                  ((state_q == ST_WR) && core_we_i);

  // Credit is judged on the registered count, so a freed slot is usable one
  // cycle after its response. Reset gates every valid combinationally.
  assign issuable = !rst_i && core_req_i && (cnt_q < CNT_MAX) && dir_ok;

  assign axi_arvalid_o = issuable && !core_we_i;
  assign axi_awvalid_o = issuable && core_we_i && !aw_done_q;
  assign axi_wvalid_o  = issuable && core_we_i && !w_done_q;

  assign axi_araddr_o = core_addr_i;
  assign axi_awaddr_o = core_addr_i;
  assign axi_wdata_o  = core_wdata_i;
  assign axi_wstrb_o  = core_be_i;
  assign axi_arprot_o = PROT;
  assign axi_awprot_o = PROT;

  assign ar_hs = axi_arvalid_o && axi_arready_i;
  assign aw_hs = axi_awvalid_o && axi_awready_i;
  assign w_hs  = axi_wvalid_o && axi_wready_i;

  // A write is granted when both halves are done, counting handshakes that
  // complete in this very cycle.
  assign gnt = ar_hs ||
               (issuable && core_we_i && (aw_done_q || aw_hs) && (w_done_q || w_hs));

  assign axi_rready_o = (state_q == ST_RD) && (cnt_q != '0);
  assign axi_bready_o = (state_q == ST_WR) && (cnt_q != '0);

  assign r_hs = axi_rvalid_i && axi_rready_o;
  assign b_hs = axi_bvalid_i && axi_bready_o;
  assign rsp  = r_hs || b_hs;

  assign core_gnt_o    = gnt;
  assign core_rvalid_o = rsp;
  assign core_rdata_o  = r_hs ? axi_rdata_i : '0;
  assign core_err_o    = (r_hs && axi_rresp_i[1]) || (b_hs && axi_bresp_i[1]);

  always_comb begin
    cnt_d = cnt_q;
    if (gnt && !rsp) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!gnt && rsp) begin
      cnt_d = cnt_q - CW'(1);
    end

    state_d = state_q;
    if (gnt) begin
      state_d = core_we_i ? ST_WR : ST_RD;
    end else if (cnt_d == '0) begin
      state_d = ST_IDLE;
    end

    aw_done_d = gnt ? 1'b0 : (aw_done_q || aw_hs);
    w_done_d  = gnt ? 1'b0 : (w_done_q || w_hs);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: doc/core2axi4l_pipe.md
CORE2AXI4L_PIPE -- requirements
Module: core2axi4l_pipe

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width.
REQ-002 SHALL have parameter DW, default 32 (32 or 64), meaning data width; strobe width is DW/8.
REQ-003 SHALL have parameter MAX_OUT, default 4 (1..16), meaning the maximum number of outstanding AXI transactions.
REQ-004 SHALL have parameter PROT, default 3'b000, driven on awprot and arprot.
REQ-005 Ports (clock and reset first), each name / direction / width / meaning:
- clk / in / 1 / sole clock, rising edge.
- rst / in / 1 / asynchronous, active-high reset.
- core_req, core_we / in / 1 each / request, write-enable.
- core_be / in / DW/8 / byte enables.
- core_addr / in / AW / address.
- core_wdata / in / DW / write data.
- core_gnt, core_rvalid, core_err / out / 1 each / grant, response valid, response error.
- core_rdata / out / DW / read data.
- axi_aw{valid,ready,addr,prot}, axi_w{valid,ready,data,strb}, axi_b{valid,ready,resp}, axi_ar{valid,ready,addr,prot}, axi_r{valid,ready,data,resp} / master direction / standard AXI4-Lite widths / AXI4-Lite master port.

Function
REQ-006 SHALL hold the direction state machine {IDLE, RD, WR} and the outstanding counter cnt (width $clog2(MAX_OUT+1)).
REQ-007 Core SHALL hold req/we/addr/wdata/be stable from request until gnt; the block does not register them; axaddr, wdata and wstrb are pass-through.
REQ-008 A request SHALL be issuable when cnt < MAX_OUT and either state==IDLE, or state==RD with we=0, or state==WR with we=1.
REQ-009 A read request SHALL assert arvalid only when issuable; gnt=1 in the cycle of arvalid&arready; the state becomes RD.
REQ-010 A write request SHALL assert awvalid unless aw_done and wvalid unless w_done, only when issuable; aw_done/w_done are set on the respective handshake.
REQ-011 A write SHALL be granted in the cycle its second handshake completes, AW and W handshakes in the same cycle included; aw_done and w_done clear on gnt; the state becomes WR.
REQ-012 An opposite-direction request while cnt>0 SHALL stall with no valid asserted until cnt==0 (registered value).
REQ-013 rready SHALL be 1 iff state==RD and cnt>0; bready SHALL be 1 iff state==WR and cnt>0.
REQ-014 core_rvalid SHALL be 1 in the cycle of r or b handshake (zero latency, in issue order).
REQ-015 core_rdata SHALL equal rdata on read responses and 0 otherwise.
REQ-016 core_err SHALL be 1 with core_rvalid when the response is SLVERR or DECERR (resp[1]=1), and 0 otherwise.
REQ-017 cnt SHALL increment on gnt and decrement on response; simultaneous gnt and response leave cnt unchanged.
REQ-018 No same-cycle credit: at cnt==MAX_OUT, issue SHALL wait one cycle after a response.
REQ-019 State SHALL return to IDLE when cnt reaches 0 with no gnt in that cycle.
REQ-020 A handshake accepted on AW or W SHALL never be re-presented; once awvalid or wvalid is asserted, it SHALL be held until its ready.
REQ-021 Once arvalid is asserted, arvalid SHALL be held until arready.

Reset
REQ-022 On rst, state SHALL be IDLE, cnt 0, and aw_done/w_done 0.
REQ-023 All valid/ready outputs, gnt, rvalid and err SHALL be 0 during reset.
REQ-024 Reset mid-transaction SHALL abandon in-flight AXI transfers without any core response.

Verification
REQ-025 Single read: arready=1, then rvalid two cycles later with rdata=0xDEADBEEF and resp=OKAY -> gnt in cycle 0, core_rvalid=1 with rdata 0xDEADBEEF and err=0, cnt returns to 0.
REQ-026 Write skew: awready=1 at cycle 0, wready delayed to cycle 3 -> awvalid drops after cycle 0, gnt at cycle 3, a single core_rvalid on bvalid.
REQ-027 Pipelined reads with MAX_OUT=4: six back-to-back reads with arready=1 and R responses stalled -> four grants, the fifth stalls until the first R handshake plus one cycle, responses returned in order.
REQ-028 Direction switch: two reads outstanding, then a write request -> no awvalid/wvalid until both R responses complete, then the write proceeds.
REQ-029 Error response: bresp=SLVERR (2'b10) -> core_err=1 with core_rvalid; DECERR on R likewise.
REQ-030 Reset with 3 reads outstanding -> all outputs 0, cnt=0, and a subsequent write is granted normally.
